// File: rtl/umi_pkg.sv
// Shared UMI definitions for the register poller: opcodes, command field
// offsets, poller state encoding and the read-command builder.
package umi_pkg;

  localparam logic [4:0] UMI_REQ_READ  = 5'h01;
  localparam logic [4:0] UMI_RESP_READ = 5'h02;

  localparam int CMD_OPCODE_LSB = 0;
  localparam int CMD_SIZE_LSB   = 5;
  localparam int CMD_LEN_LSB    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    WAIT = 2'd3
  } poll_state_t;

  // Single-word read: opcode, log2(bytes) size, len 0, all upper bits zero.
  function automatic logic [15:0] read_cmd(input logic [2:0] size);
    logic [15:0] c;
    c = '0;
    c[CMD_OPCODE_LSB +: 5] = UMI_REQ_READ;
    c[CMD_SIZE_LSB +: 3]   = size;
    c[CMD_LEN_LSB +: 8]    = 8'h00;
    return c;
  endfunction

endpackage

// File: rtl/umi_poll_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
// Loaded with N it reports done in the (N+1)th cycle after the load.
module umi_poll_timer #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic          done
);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/umi_reg_poller.sv
// UMI host-side poller: repeatedly reads one register through a UMI endpoint,
// publishes the latest value, flags response timeouts and counts stray responses.
module umi_reg_poller
  import umi_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic [PW-1:0] timeout,
  input  logic [AW-1:0] target_addr,
  input  logic [AW-1:0] host_addr,
  output logic          uhost_req_valid,
  input  logic          uhost_req_ready,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_resp_valid,
  output logic          uhost_resp_ready,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic [DW-1:0] value,
  output logic          value_valid,
  output logic          timeout_err,
  output logic [7:0]    stray_cnt
);

  localparam logic [2:0] SIZE = 3'($clog2(DW / 8));

  // A phase of length N occupies max(N,1) cycles, so the timer is loaded with N-1.
  function automatic logic [PW-1:0] phase_len(input logic [PW-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  poll_state_t   state, state_nxt;
  logic [AW-1:0] dst_q, src_q;
  logic          tmo_en_q;
  logic          resp_ready_q;
  logic          req_hs, resp_hs, resp_match, tmo_hit;
  logic          wait_load, wait_done, tmo_done;
  logic          unused_bits;

  assign req_hs     = (state == REQ) && uhost_req_ready;
  assign resp_hs    = uhost_resp_valid && resp_ready_q;
  assign resp_match = (state == RESP) && resp_hs &&
                      (uhost_resp_cmd[4:0] == UMI_RESP_READ) &&
                      (uhost_resp_dstaddr == src_q);
  assign tmo_hit    = (state == RESP) && tmo_en_q && tmo_done;
  assign wait_load  = (state_nxt == WAIT) && (state != WAIT);

  umi_poll_timer #(.PW(PW)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (phase_len(period)),
    .done     (wait_done)
  );

  umi_poll_timer #(.PW(PW)) u_tmo_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (req_hs),
    .load_val (phase_len(timeout)),
    .done     (tmo_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = REQ;
      REQ:     if (uhost_req_ready) state_nxt = RESP;
      RESP:    if (resp_match || tmo_hit) state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = enable ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uhost_req_valid = 1'b0;
    uhost_req_cmd   = '0;
    if (state == REQ) begin
      uhost_req_valid = 1'b1;
      uhost_req_cmd   = CW'(read_cmd(SIZE));
    end
  end

  // Request fields are captured on every entry to REQ and held until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_q        <= '0;
      src_q        <= '0;
      tmo_en_q     <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      resp_ready_q <= 1'b1;
      if ((state_nxt == REQ) && (state != REQ)) begin
        dst_q <= target_addr;
        src_q <= host_addr;
      end
      if (req_hs) tmo_en_q <= (timeout != '0);
    end
  end

  // A match outranks a timeout expiring in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value       <= '0;
      value_valid <= 1'b0;
      timeout_err <= 1'b0;
      stray_cnt   <= '0;
    end else begin
      value_valid <= resp_match;
      if (resp_match) begin
        value       <= uhost_resp_data;
        timeout_err <= 1'b0;
      end else if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
      if (resp_hs && !resp_match && (stray_cnt != 8'hFF)) stray_cnt <= stray_cnt + 8'd1;
    end
  end

  assign uhost_req_dstaddr = dst_q;
  assign uhost_req_srcaddr = src_q;
  assign uhost_req_data    = '0;
  assign uhost_resp_ready  = resp_ready_q;

  assign unused_bits = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

endmodule

// File: tb/tb_umi_reg_poller.sv
// Directed bench for umi_reg_poller: steady polling, stalled request, timeout,
// stray responses, match/timeout tie, mid-transaction reset, stray saturation.
module tb_umi_reg_poller;

  localparam logic [63:0] TGT  = 64'h1000;
  localparam logic [63:0] HOST = 64'h2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] timeout = '0;
  logic [63:0] target_addr = TGT;
  logic [63:0] host_addr = HOST;
  logic        uhost_req_valid;
  logic        uhost_req_ready = 1'b0;
  logic [31:0] uhost_req_cmd;
  logic [63:0] uhost_req_dstaddr;
  logic [63:0] uhost_req_srcaddr;
  logic [31:0] uhost_req_data;
  logic        uhost_resp_valid = 1'b0;
  logic        uhost_resp_ready;
  logic [31:0] uhost_resp_cmd = '0;
  logic [63:0] uhost_resp_dstaddr = '0;
  logic [63:0] uhost_resp_srcaddr = '0;
  logic [31:0] uhost_resp_data = '0;
  logic [31:0] value;
  logic        value_valid;
  logic        timeout_err;
  logic [7:0]  stray_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  umi_reg_poller dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .period             (period),
    .timeout            (timeout),
    .target_addr        (target_addr),
    .host_addr          (host_addr),
    .uhost_req_valid    (uhost_req_valid),
    .uhost_req_ready    (uhost_req_ready),
    .uhost_req_cmd      (uhost_req_cmd),
    .uhost_req_dstaddr  (uhost_req_dstaddr),
    .uhost_req_srcaddr  (uhost_req_srcaddr),
    .uhost_req_data     (uhost_req_data),
    .uhost_resp_valid   (uhost_resp_valid),
    .uhost_resp_ready   (uhost_resp_ready),
    .uhost_resp_cmd     (uhost_resp_cmd),
    .uhost_resp_dstaddr (uhost_resp_dstaddr),
    .uhost_resp_srcaddr (uhost_resp_srcaddr),
    .uhost_resp_data    (uhost_resp_data),
    .value              (value),
    .value_valid        (value_valid),
    .timeout_err        (timeout_err),
    .stray_cnt          (stray_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_resp(input logic [31:0] cmd, input logic [63:0] dst, input logic [31:0] data);
    uhost_resp_valid   = 1'b1;
    uhost_resp_cmd     = cmd;
    uhost_resp_dstaddr = dst;
    uhost_resp_data    = data;
  endtask

  // Called in the first REQ cycle with ready high; returns in the next REQ cycle.
  task automatic poll_once(input string tag, input int lat, input logic [31:0] data, input int exp_gap);
    int gap;
    check_val({tag, "_req_valid"}, 64'(uhost_req_valid), 64'd1);
    check_val({tag, "_cmd"}, 64'(uhost_req_cmd), 64'h41);
    check_val({tag, "_dst"}, uhost_req_dstaddr, TGT);
    check_val({tag, "_src"}, uhost_req_srcaddr, HOST);
    check_val({tag, "_data"}, 64'(uhost_req_data), 64'd0);
    tick;
    check_val({tag, "_valid_drop"}, 64'(uhost_req_valid), 64'd0);
    repeat (lat) tick;
    drive_resp(32'h42, HOST, data);
    tick;
    uhost_resp_valid = 1'b0;
    check_val({tag, "_vv"}, 64'(value_valid), 64'd1);
    check_val({tag, "_value"}, 64'(value), 64'(data));
    gap = 0;
    while (!uhost_req_valid && gap < 64) begin
      tick;
      gap++;
      if (gap == 1) check_val({tag, "_vv_pulse"}, 64'(value_valid), 64'd0);
    end
    check_val({tag, "_gap"}, 64'(gap), 64'(exp_gap));
  endtask

  initial begin
    bit seen;

    // Reset state
    tick;
    tick;
    check_val("rst_req_valid", 64'(uhost_req_valid), 64'd0);
    check_val("rst_resp_ready", 64'(uhost_resp_ready), 64'd0);
    check_val("rst_value", 64'(value), 64'd0);
    check_val("rst_stray", 64'(stray_cnt), 64'd0);
    reset = 1'b0;
    tick;
    check_val("resp_ready_up", 64'(uhost_resp_ready), 64'd1);

    // 1: steady polling, period 4, no timeout
    period = 16'd4;
    timeout = 16'd0;
    uhost_req_ready = 1'b1;
    enable = 1'b1;
    tick;
    poll_once("t1a", 0, 32'hCAFE0001, 4);
    poll_once("t1b", 2, 32'h12345678, 4);

    // 2: stalled handshake, enable dropped mid-REQ, target changed mid-REQ
    uhost_req_ready = 1'b0;
    period = 16'd0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!uhost_req_valid || uhost_req_dstaddr !== TGT || uhost_req_cmd !== 32'h41) seen = 1'b1;
      if (k == 2) begin
        enable = 1'b0;
        target_addr = 64'hDEAD;
      end
      tick;
    end
    check_val("t2_stable", 64'(seen), 64'd0);
    check_val("t2_still_valid", 64'(uhost_req_valid), 64'd1);
    uhost_req_ready = 1'b1;
    tick;
    check_val("t2_hs", 64'(uhost_req_valid), 64'd0);
    drive_resp(32'h42, HOST, 32'h22);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t2_value", 64'(value), 64'h22);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (uhost_req_valid) seen = 1'b1;
    end
    check_val("t2_idle", 64'(seen), 64'd0);

    // 3: timeout after 5 cycles, late response is stray, next good response clears
    target_addr = TGT;
    timeout = 16'd5;
    enable = 1'b1;
    tick;
    check_val("t3_req", 64'(uhost_req_valid), 64'd1);
    tick;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (timeout_err) seen = 1'b1;
    end
    check_val("t3_early", 64'(seen), 64'd0);
    tick;
    check_val("t3_err", 64'(timeout_err), 64'd1);
    drive_resp(32'h42, HOST, 32'hBEEF);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t3_late_stray", 64'(stray_cnt), 64'd1);
    check_val("t3_late_value", 64'(value), 64'h22);
    check_val("t3_sticky", 64'(timeout_err), 64'd1);
    check_val("t3_reissue", 64'(uhost_req_valid), 64'd1);
    enable = 1'b0;
    tick;
    drive_resp(32'h42, HOST, 32'h33);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t3_clear", 64'(timeout_err), 64'd0);
    check_val("t3_value", 64'(value), 64'h33);
    tick;

    // 4: wrong dstaddr and wrong opcode are stray, then a good response
    timeout = 16'd0;
    enable = 1'b1;
    tick;
    enable = 1'b0;
    tick;
    drive_resp(32'h42, 64'h9999, 32'hBAD);
    tick;
    check_val("t4_stray1", 64'(stray_cnt), 64'd2);
    check_val("t4_no_vv", 64'(value_valid), 64'd0);
    drive_resp(32'h41, HOST, 32'hBAD);
    tick;
    check_val("t4_stray2", 64'(stray_cnt), 64'd3);
    drive_resp(32'h42, HOST, 32'h44);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t4_value", 64'(value), 64'h44);
    check_val("t4_vv", 64'(value_valid), 64'd1);
    check_val("t4_stray_hold", 64'(stray_cnt), 64'd3);
    tick;

    // 5: match on the same cycle the timeout expires
    timeout = 16'd3;
    enable = 1'b1;
    tick;
    enable = 1'b0;
    tick;
    tick;
    tick;
    drive_resp(32'h42, HOST, 32'h55);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t5_value", 64'(value), 64'h55);
    check_val("t5_vv", 64'(value_valid), 64'd1);
    check_val("t5_err", 64'(timeout_err), 64'd0);
    tick;

    // 6: reset while waiting for a response
    timeout = 16'd0;
    enable = 1'b1;
    tick;
    tick;
    check_val("t6_in_resp", 64'(uhost_req_valid), 64'd0);
    reset = 1'b1;
    #1;
    check_val("t6_rst_value", 64'(value), 64'd0);
    check_val("t6_rst_stray", 64'(stray_cnt), 64'd0);
    check_val("t6_rst_ready", 64'(uhost_resp_ready), 64'd0);
    check_val("t6_rst_dst", uhost_req_dstaddr, 64'd0);
    tick;
    reset = 1'b0;
    tick;
    check_val("t6_restart", 64'(uhost_req_valid), 64'd1);
    check_val("t6_restart_dst", uhost_req_dstaddr, TGT);
    enable = 1'b0;
    tick;
    drive_resp(32'h42, HOST, 32'h66);
    tick;
    uhost_resp_valid = 1'b0;
    check_val("t6_value", 64'(value), 64'h66);
    tick;

    // 7: stray counter saturates
    drive_resp(32'h42, HOST, 32'h77);
    repeat (260) tick;
    uhost_resp_valid = 1'b0;
    check_val("t7_saturate", 64'(stray_cnt), 64'd255);
    check_val("t7_value_kept", 64'(value), 64'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
